// File: rtl/sw_time_cnt.sv
// Stopwatch time counter: BCD centiseconds/seconds/minutes driven by 100 Hz pulse edges,
// with run/stop, clear, lap-freeze of the display and overflow flag.
module sw_time_cnt #(
   parameter int MIN_MAX = 59,
   parameter bit WRAP    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run_md,
   input  logic       clr_on,
   input  logic       lap_on,
   input  logic       pls_100hz,
   output logic [7:0] cs_bcd,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic       lap_hold,
   output logic       sec_pls,
   output logic       ovf
);

   localparam logic [7:0] MIN_TOP = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

   logic       pls_x0_q, pls_x1_q, clr_x0_q, clr_x1_q, lap_x0_q, lap_x1_q;
   logic [7:0] cs_q, sec_q, min_q;
   logic [7:0] cs_d, sec_d, min_d;
   logic [7:0] cs_disp_q, sec_disp_q, min_disp_q;
   logic       lap_q, lap_d;
   logic       secp_q, secp_d;
   logic       ovf_q, ovf_d;
   logic       tick, clr_evt, lap_evt, at_top;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   always_comb begin
      tick    = pls_x0_q & ~pls_x1_q & run_md;
      clr_evt = clr_x0_q & ~clr_x1_q & ~run_md;
      lap_evt = lap_x0_q & ~lap_x1_q & run_md;
      at_top  = (min_q == MIN_TOP) && (sec_q == 8'h59) && (cs_q == 8'h99);

      cs_d   = cs_q;
      sec_d  = sec_q;
      min_d  = min_q;
      lap_d  = lap_q;
      ovf_d  = ovf_q;
      secp_d = 1'b0;

      if (clr_evt) begin
         cs_d  = '0;
         sec_d = '0;
         min_d = '0;
         ovf_d = 1'b0;
         lap_d = 1'b0;
      end else begin
         if (lap_evt) lap_d = ~lap_q;
         if (tick) begin
            if (at_top) begin
               ovf_d = 1'b1;
               if (WRAP) begin
                  cs_d   = '0;
                  sec_d  = '0;
                  min_d  = '0;
                  secp_d = 1'b1;
               end
            end else if (cs_q == 8'h99) begin
               cs_d   = '0;
               secp_d = 1'b1;
               if (sec_q == 8'h59) begin
                  sec_d = '0;
                  min_d = bcd_inc(min_q);
               end else begin
                  sec_d = bcd_inc(sec_q);
               end
            end else begin
               cs_d = bcd_inc(cs_q);
            end
         end
      end
   end

   // Display samples the pre-update live count, so a lap coinciding with a tick freezes the pre-tick value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pls_x0_q   <= 1'b0;
         pls_x1_q   <= 1'b0;
         clr_x0_q   <= 1'b0;
         clr_x1_q   <= 1'b0;
         lap_x0_q   <= 1'b0;
         lap_x1_q   <= 1'b0;
         cs_q       <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         cs_disp_q  <= '0;
         sec_disp_q <= '0;
         min_disp_q <= '0;
         lap_q      <= 1'b0;
         secp_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         pls_x0_q <= pls_100hz;
         pls_x1_q <= pls_x0_q;
         clr_x0_q <= clr_on;
         clr_x1_q <= clr_x0_q;
         lap_x0_q <= lap_on;
         lap_x1_q <= lap_x0_q;
         cs_q     <= cs_d;
         sec_q    <= sec_d;
         min_q    <= min_d;
         lap_q    <= lap_d;
         secp_q   <= secp_d;
         ovf_q    <= ovf_d;
         if (!lap_q) begin
            cs_disp_q  <= cs_q;
            sec_disp_q <= sec_q;
            min_disp_q <= min_q;
         end
      end
   end

   assign cs_bcd   = cs_disp_q;
   assign sec_bcd  = sec_disp_q;
   assign min_bcd  = min_disp_q;
   assign lap_hold = lap_q;
   assign sec_pls  = secp_q;
   assign ovf      = ovf_q;

endmodule
